if_fetch_buffer: RTL
====================

// Module: if_fetch_buffer
// PURPOSE
//  Instruction-fetch stage that consumes the PC stream from the PC generator.
//  - Issues each PC to the synchronous instruction memory.
//  - Captures the returned word with its PC in a small FIFO and presents them to decode.
//  - Sends hold back to the PC generator so the PC advances only when a fetch is issued.
//  - Branch flush discards buffered and in-flight instructions.
// PARAMETERS
//  PC_WIDTH   12  word-address width of PC / instruction memory
//  INST_WIDTH 32  instruction width
//  DEPTH      4   FIFO entries; power of two, >=2
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           reset; one clock; reset is synchronous and active-high
//  pc_in        in   PC_WIDTH    current PC from PC generator
//  flush        in   1           branch taken; PC generator loads branch target this cycle
//  hold_out     out  1           to PC generator hold: 1 = keep PC
//  imem_req     out  1           instruction memory read strobe
//  imem_addr    out  PC_WIDTH    read address (= pc_in when imem_req)
//  imem_rdata   in   INST_WIDTH  read data, valid exactly 1 cycle after imem_req
//  inst_valid   out  1           FIFO head valid
//  inst_ready   in   1           decode accepts head
//  inst_out     out  INST_WIDTH  head instruction
//  inst_pc_out  out  PC_WIDTH    PC of head instruction
// BEHAVIOUR
//  Reset state:
//  - FIFO empty, count = 0, inflight = 0, inst_valid = 0, imem_req = 0.
//  - hold_out = 1 while rst is high.
//  - inst_out and inst_pc_out read 0 after reset.
//  Occupancy and issue:
//  - occ = count + inflight.
//  - issue = !rst & !flush & (occ < DEPTH).
//  - The cycle's pop does not create issue credit.
//  - imem_req = issue; imem_addr = pc_in; hold_out = !issue & !flush.
//  - hold_out is combinational.
//  Flush:
//  - Flush forces hold_out = 0, so the PC generator takes the branch target.
//  - No request is issued in the flush cycle.
//  Response capture:
//  - inflight <= issue; req_pc <= pc_in when issue.
//  - When inflight=1 and no flush this cycle, push {imem_rdata, req_pc} into the FIFO.
//  Pop:
//  - pop = inst_valid & inst_ready; inst_valid = (count != 0).
//  - inst_out and inst_pc_out show the head entry combinationally from FIFO storage.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  - Overflow is impossible by the credit rule. Push when count==DEPTH is an assertion failure.
//  Flush clears everything in one cycle:
//  - count <= 0 and pointers <= 0.
//  - inflight <= 0; the response arriving in the next cycle is dropped.
//  - pop is ignored in the flush cycle.
//  Flush has priority over push, pop and issue.
//  Reset asserted mid-operation acts as flush and also forces hold_out = 1.
//  Latency:
//  - PC issued in cycle N -> pushed at the N+1 edge -> inst_valid in cycle N+2.
//  - Throughput is 1 instr/cycle when inst_ready stays high.
// TESTING
//  1. Reset release, pc_in 0,1,2..., inst_ready=1, mem returns addr+0x100:
//     - imem_req=1 every cycle.
//     - inst_out 0x100,0x101,... with matching PCs from cycle 2.
//     - hold_out=0 throughout.
//  2. inst_ready=0 for 10 cycles:
//     - Exactly DEPTH (4) requests are issued, then hold_out=1 and imem_req=0.
//     - The FIFO holds PCs 0..3.
//     - After inst_ready=1, PCs 0..3 drain in order and issue resumes.
//  3. Flush with 3 buffered plus 1 in flight:
//     - Next cycle inst_valid=0 and the in-flight word is not pushed.
//     - hold_out=0 in the flush cycle; no request that cycle.
//     - The next fetch uses the branch target.
//  4. Full FIFO with inst_ready=1 in the same cycle:
//     - Pop occurs, count=DEPTH-1, and no issue that cycle.
//     - Issue occurs the following cycle.
//  5. rst pulsed for 1 cycle mid-stream:
//     - FIFO empty, inst_valid=0, hold_out=1 during rst.
//     - Stale response dropped; fetch restarts at the reset PC.
//  6. Pointer wrap, 20 instructions with random inst_ready:
//     - Order and PC pairing preserved.
//     - Check the scoreboard against the memory model.

Source files
------------

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer: issues PCs to a synchronous instruction memory, captures
// each returned word with its PC in a small FIFO, and presents the head to decode.
// Issue is credit-based: a request goes out only when buffered plus in-flight entries
// leave room, so the FIFO can never overflow.
module if_fetch_buffer #(
    parameter int unsigned PC_WIDTH   = 12,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic                  flush,
    output logic                  hold_out,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [PC_WIDTH-1:0]   inst_pc_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   DepthCnt = (AW + 1)'(DEPTH);
    localparam logic [AW+1:0] DepthOcc = (AW + 2)'(DEPTH);

    logic [AW:0]           count_q, count_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  inflight_q;
    logic [PC_WIDTH-1:0]   req_pc_q;
    logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];

    logic [AW+1:0] occ;
    logic          kill;
    logic          issue;
    logic          push;
    logic          pop;

    // Issue credit, PC-generator handshake and FIFO push/pop qualification.
    // Reset behaves as a flush that additionally holds the PC generator.
    always_comb begin
        kill       = rst | flush;
        occ        = {1'b0, count_q} + {{(AW + 1){1'b0}}, inflight_q};
        // The current cycle's pop deliberately does not count as free space.
        issue      = !kill && (occ < DepthOcc);
        imem_req   = issue;
        imem_addr  = pc_in;
        hold_out   = rst | (!issue & !flush);
        inst_valid = (count_q != '0);
        push       = inflight_q & !kill;
        pop        = inst_valid & inst_ready & !kill;
    end

    // Next-state for occupancy and pointers; flush/reset empties the FIFO at once.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers and FIFO storage; storage is cleared on reset so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            // issue is already 0 on flush, which drops the next cycle's response.
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= pc_in;
            end
            if (push) begin
                inst_mem_q[wr_ptr_q] <= imem_rdata;
                pc_mem_q[wr_ptr_q]   <= req_pc_q;
            end
        end
    end

    // Credit rule guarantees a full FIFO never sees a response arrive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count_q == DepthCnt)));
        end
    end

    // Head entry is read straight from storage.
    always_comb begin
        inst_out    = inst_mem_q[rd_ptr_q];
        inst_pc_out = pc_mem_q[rd_ptr_q];
    end

endmodule
